// File: rtl/debug_word_uart_tx.sv
// debug_word_uart_tx
//   Debug-side UART transmitter. Serialises a 32-bit word (PC, register or memory
//   snapshot) to the host as 4 UART bytes, least significant byte first. Frames are
//   8N1 by default. Words arrive over a valid/ready handshake.
//
//   Optional feature macro: PARITY_EN
//     defined   : an even-parity bit is inserted after the data bits (8E1, 11 bits/byte)
//     undefined : plain 8N1, no parity state or logic (10 bits/byte)
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//   WORD_W        input word width; only 32 is supported
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset; aborts any frame in flight
//   i_word   in   word to transmit, captured on the accepting edge
//   i_valid  in   i_word is valid
//   o_ready  out  block is idle and can accept a word
//   o_tx     out  UART serial line, idle high
//   o_busy   out  frame in progress (inverse of o_ready)
//   o_done   out  one-cycle pulse in the first idle cycle after byte 3's stop bit
module debug_word_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned WORD_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_done
);

    localparam int unsigned     BaudW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [1:0]       ByteLast = 2'(WORD_W / 8 - 1);

`ifdef PARITY_EN
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;
`endif

    state_e            state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [1:0]        byte_q, byte_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              done_q, done_d;
    logic              bit_end;
`ifdef PARITY_EN
    logic              parity_q, parity_d;
`endif

    assign bit_end = (baud_q == BaudLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            shift_q  <= '0;
            done_q   <= 1'b0;
`ifdef PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            shift_q  <= shift_d;
            done_q   <= done_d;
`ifdef PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        shift_d  = shift_q;
        done_d   = 1'b0;
`ifdef PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            StIdle: begin
                if (i_valid) begin
                    shift_d = i_word;
                    baud_d  = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    baud_d   = '0;
                    bit_d    = '0;
`ifdef PARITY_EN
                    parity_d = 1'b0;
`endif
                    state_d  = StData;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    baud_d   = '0;
                    // Shifting the whole word leaves the next byte in [7:0].
                    shift_d  = shift_q >> 1;
`ifdef PARITY_EN
                    parity_d = parity_q ^ shift_q[0];
`endif
                    if (bit_q == 3'd7) begin
`ifdef PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef PARITY_EN
            StParity: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = StStop;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (byte_q == ByteLast) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        state_d = StStart;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        o_tx = 1'b1;
        case (state_q)
            StStart:  o_tx = 1'b0;
            StData:   o_tx = shift_q[0];
`ifdef PARITY_EN
            StParity: o_tx = parity_q;
`endif
            default:  o_tx = 1'b1;
        endcase
    end

    assign o_ready = (state_q == StIdle);
    assign o_busy  = ~o_ready;
    assign o_done  = done_q;

endmodule

// File: tb/tb_debug_word_uart_tx.sv
// Scoreboard bench for debug_word_uart_tx. The driver pushes expected bytes (with
// their expected start-bit cycle) and the expected o_done cycle when a word is
// accepted; negedge monitors decode the serial line and pop/compare.
module tb_debug_word_uart_tx;

    localparam int C = 16;
`ifdef PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME  = 4 * NB * C;
    localparam int BUDGET = 3 * FRAME;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] i_word = '0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        o_tx;
    logic        o_busy;
    logic        o_done;

    debug_word_uart_tx #(
        .CLKS_PER_BIT(C),
        .WORD_W      (32)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .i_word (i_word),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .o_tx   (o_tx),
        .o_busy (o_busy),
        .o_done (o_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_byte_t;

    exp_byte_t byte_q[$];
    int        done_q[$];
    int        n_cmp = 0;
    int        n_err = 0;
    bit        mon_en = 1'b0;
    bit        have_acc = 1'b0;
    int        last_acc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_cmp++;
        n_err++;
        $display("FAIL %s: %s at cycle %0d", name, what, cyc);
    endtask

    // Line monitor: decodes frames and compares against the byte scoreboard.
    bit           mon_act = 1'b0;
    int           mon_cnt = 0;
    exp_byte_t    cur;
    logic [NB-1:0] fbits;

    always @(negedge clk) begin
        if (mon_en) begin
            if (reset) begin
                mon_act = 1'b0;
            end else begin
                logic exp_ready;
                exp_ready = !(have_acc && cyc >= last_acc && cyc < last_acc + FRAME);
                check("ready", o_ready, exp_ready);
                check("busy", o_busy, !exp_ready);
                if (o_done === 1'b1) begin
                    check("done_ready", o_ready, 1'b1);
                    if (done_q.size() == 0) fail("done", "unexpected o_done pulse");
                    else check("done_cycle", cyc, done_q.pop_front());
                end
                if (mon_act) begin
                    mon_cnt++;
                    if (mon_cnt % C == C / 2) fbits[mon_cnt / C] = o_tx;
                    if (mon_cnt == NB * C - 1) begin
                        mon_act = 1'b0;
                        check("start_bit", fbits[0], 1'b0);
                        check("data_byte", fbits[8:1], cur.data);
`ifdef PARITY_EN
                        check("parity_bit", fbits[9], ^cur.data);
`endif
                        check("stop_bit", fbits[NB-1], 1'b1);
                    end
                end else if (o_tx === 1'b0) begin
                    mon_act = 1'b1;
                    mon_cnt = 0;
                    fbits   = '1;
                    if (byte_q.size() == 0) begin
                        fail("start", "unexpected start bit");
                        cur.data  = 8'hxx;
                        cur.start = -1;
                    end else begin
                        cur = byte_q.pop_front();
                        check("start_cycle", cyc, cur.start);
                    end
                end
            end
        end
    end

    // Offer a word; returns the cycle number of the accepting edge (-1 on timeout).
    // Entered and left at posedge+1; i_valid is left high for the caller.
    task automatic offer(input logic [31:0] w, output int acc);
        int k;
        acc     = -1;
        i_word  = w;
        i_valid = 1'b1;
        for (k = 0; k < BUDGET; k++) begin
            if (o_ready) begin
                acc = cyc + 1;
                for (int b = 0; b < 4; b++) begin
                    byte_q.push_back('{data: w[8*b +: 8], start: acc + b * NB * C});
                end
                done_q.push_back(acc + FRAME);
                have_acc = 1'b1;
                last_acc = acc;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (acc < 0) fail("accept", "word never accepted");
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < BUDGET; k++) begin
            if (byte_q.size() == 0 && done_q.size() == 0 && !mon_act) break;
            @(posedge clk);
            #1;
        end
        if (k == BUDGET) fail("drain", "scoreboard not drained");
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int a1;
        int a2;

        // Reset held for two cycles.
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_tx", o_tx, 1'b1);
            check("rst_ready", o_ready, 1'b1);
            check("rst_busy", o_busy, 1'b0);
            check("rst_done", o_done, 1'b0);
        end
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end

        // Single word, single-cycle valid.
        offer(32'h12345678, a1);
        i_valid = 1'b0;
        check("latency_tx", o_tx, 1'b0);
        wait_idle();

        // Valid held across two words: second accepted on the o_done cycle.
        offer(32'hA5A5A5A5, a1);
        offer(32'h0000FFFF, a2);
        i_valid = 1'b0;
        check("b2b_accept", a2, a1 + FRAME + 1);
        wait_idle();

        // Input changes while busy must not disturb the frame.
        offer(32'h0BADF00D, a1);
        i_valid = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1;
        end
        i_word  = 32'hFFFFFFFF;
        i_valid = 1'b1;
        repeat (300) begin
            @(posedge clk);
            #1;
        end
        check("busy_ready", o_ready, 1'b0);
        i_valid = 1'b0;
        i_word  = '0;
        wait_idle();

        // Reset during byte 2 aborts the word without o_done.
        offer(32'hDEADBEEF, a1);
        i_valid = 1'b0;
        repeat (2 * NB * C + 37) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        byte_q.delete();
        done_q.delete();
        have_acc = 1'b0;
        @(posedge clk);
        #1;
        check("abort_tx", o_tx, 1'b1);
        check("abort_ready", o_ready, 1'b1);
        check("abort_busy", o_busy, 1'b0);
        check("abort_done", o_done, 1'b0);
        reset = 1'b0;
        repeat (50) begin
            @(posedge clk);
            #1;
        end
        offer(32'hCAFEF00D, a1);
        i_valid = 1'b0;
        wait_idle();

        // Parity pattern word (plain 8N1 framing without PARITY_EN).
        offer(32'h00000103, a1);
        i_valid = 1'b0;
        wait_idle();

        // Randomised words, gaps and held-valid runs.
        for (int n = 0; n < 10; n++) begin
            offer($urandom, a1);
            if ($urandom_range(0, 1) == 0) begin
                i_valid = 1'b0;
                repeat ($urandom_range(0, 20)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        i_valid = 1'b0;
        wait_idle();

        check("left_bytes", byte_q.size(), 0);
        check("left_done", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
